// File: rtl/yuyv_capture_dma_if.sv
// Bus bundle for yuyv_capture_dma: CSR slave, YUYV pixel stream and 16-bit Avalon-MM write master.
// The slave modport is the capture block's view; the master modport is the surrounding system's view.
interface yuyv_capture_dma_if;
    logic [2:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_readdata;
    logic [31:0] s_writedata;
    logic [15:0] st_data;
    logic        st_valid;
    logic        st_sof;
    logic        st_ready;
    logic        m_waitrequest;
    logic [30:0] m_address;
    logic        m_write;
    logic [15:0] m_writedata;
    logic [1:0]  m_byteenable;
    logic        irq;

    modport slave (
        input  s_address, s_read, s_write, s_writedata,
        input  st_data, st_valid, st_sof,
        input  m_waitrequest,
        output s_readdata, st_ready,
        output m_address, m_write, m_writedata, m_byteenable,
        output irq
    );

    modport master (
        output s_address, s_read, s_write, s_writedata,
        output st_data, st_valid, st_sof,
        output m_waitrequest,
        input  s_readdata, st_ready,
        input  m_address, m_write, m_writedata, m_byteenable,
        input  irq
    );
endinterface

// File: rtl/yuyv_capture_dma.sv
// Captures one YUYV 4:2:2 frame from a non-stallable camera stream into memory via a FIFO-fed write master.
// Optional macro CAPTURE_DROP_COUNT_EN adds a saturating dropped-word counter readable at CSR 6.
module yuyv_capture_dma #(
    parameter int FIFO_DEPTH = 16
) (
    input logic               clk,
    input logic               rst,
    yuyv_capture_dma_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0] width_q, height_q;
    logic [30:0] dst_q, base_q;
    logic [31:0] size_q, n_q, accepted_q, retired_q;
    logic        err_q, ovf_q;
    logic [31:0] frame_words, wdata_swap, rdata;
    logic        start_req, capture_start, push_req, sof_err, busy, irq_c;

    logic [46:0]   fifo_mem [FIFO_DEPTH];
    logic [46:0]   head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, push, pop, drop;

`ifdef CAPTURE_DROP_COUNT_EN
    logic [31:0] drop_cnt_q;
`endif

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    assign frame_words = {16'h0, width_q} * {16'h0, height_q};
    assign wdata_swap  = bswap32(bus.s_writedata);
    assign start_req   = bus.s_write && (bus.s_address == 3'd5);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        irq_c         = 1'b0;
        push_req      = 1'b0;
        capture_start = 1'b0;
        sof_err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    capture_start = 1'b1;
                    state_d = (frame_words == 32'd0) ? S_DONE : S_ARMED;
                end
            end
            S_ARMED: begin
                busy = 1'b1;
                if (bus.st_valid && bus.st_sof) begin
                    push_req = 1'b1;
                    state_d  = (n_q == 32'd1) ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy = 1'b1;
                if (bus.st_valid && (accepted_q < n_q)) begin
                    push_req = 1'b1;
                    sof_err  = bus.st_sof;
                    if (accepted_q + 32'd1 == n_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (retired_q == n_q) state_d = S_DONE;
            end
            S_DONE: begin
                irq_c   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A dropped word still retires its slot so the frame finishes, leaving a hole at its address.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign pop   = !empty && !bus.m_waitrequest;
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            width_q    <= '0;
            height_q   <= '0;
            dst_q      <= '0;
            size_q     <= '0;
            n_q        <= '0;
            base_q     <= '0;
            accepted_q <= '0;
            retired_q  <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (bus.s_write) begin
                case (bus.s_address)
                    3'd0:    width_q  <= bswap16(bus.s_writedata[15:0]);
                    3'd1:    height_q <= bswap16(bus.s_writedata[15:0]);
                    3'd2:    dst_q    <= wdata_swap[31:1];
                    default: ;
                endcase
            end
            if (capture_start) begin
                n_q        <= frame_words;
                base_q     <= dst_q;
                accepted_q <= '0;
                retired_q  <= '0;
                err_q      <= 1'b0;
                ovf_q      <= 1'b0;
                size_q     <= '0;
            end else begin
                if (push_req) accepted_q <= accepted_q + 32'd1;
                retired_q <= retired_q + 32'(pop) + 32'(drop);
                if (sof_err) err_q <= 1'b1;
                if (drop)    ovf_q <= 1'b1;
                if (state_q == S_DONE) size_q <= {n_q[30:0], 1'b0};
            end
        end
    end

`ifdef CAPTURE_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || capture_start)            drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != '1)   drop_cnt_q <= drop_cnt_q + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Each entry carries its frame word index so the address survives dropped neighbours.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {accepted_q[30:0], bus.st_data};
    end

    assign head             = fifo_mem[rd_ptr_q];
    assign bus.m_write      = !empty;
    assign bus.m_address    = base_q + head[46:16];
    assign bus.m_writedata  = head[15:0];
    assign bus.m_byteenable = bus.m_write ? 2'b11 : 2'b00;
    assign bus.irq          = irq_c;
    assign bus.st_ready     = 1'b1;

    always_comb begin
        rdata = 32'hdeadbeef;
        if (bus.s_read) begin
            case (bus.s_address)
                3'd0:    rdata = {16'h0, bswap16(width_q)};
                3'd1:    rdata = {16'h0, bswap16(height_q)};
                3'd2:    rdata = bswap32({dst_q, 1'b0});
                3'd4:    rdata = bswap32(size_q);
                3'd5:    rdata = {5'b0, ovf_q, err_q, busy, 24'h0};
`ifdef CAPTURE_DROP_COUNT_EN
                3'd6:    rdata = bswap32(drop_cnt_q);
`endif
                default: rdata = 32'hdeadbeef;
            endcase
        end
    end

    assign bus.s_readdata = rdata;
endmodule

// File: tb/tb_yuyv_capture_dma.sv
// Bench for yuyv_capture_dma: directed frames plus random frames checked against an address/data reference
// built from frame geometry, destination address and the words that were streamed.
`timescale 1ns/1ps
module tb_yuyv_capture_dma;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    yuyv_capture_dma_if bus();

    yuyv_capture_dma #(.FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [30:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          irq_cnt, wcyc_cnt, be_bad, stab_bad;
    logic        prev_stall;
    logic [30:0] prev_addr;
    logic [15:0] prev_data;
    int          wait_mode;
    int          stall_ctr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: sim time exceeded, bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] bs32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [31:0] sw16(input logic [15:0] v);
        return {16'h0, v[7:0], v[15:8]};
    endfunction

    // Observe the bus at the falling edge: what is seen here is what the next rising edge will act on.
    initial begin
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (bus.m_write !== 1'b1 || bus.m_address !== prev_addr ||
                                   bus.m_writedata !== prev_data))
                    stab_bad++;
                if (bus.irq === 1'b1) irq_cnt++;
                if (bus.m_write === 1'b1) begin
                    wcyc_cnt++;
                    if (bus.m_byteenable !== 2'b11) be_bad++;
                    if (bus.m_waitrequest === 1'b0) begin
                        wr_addr_q.push_back(bus.m_address);
                        wr_data_q.push_back(bus.m_writedata);
                    end
                end
                prev_stall = (bus.m_write === 1'b1) && (bus.m_waitrequest === 1'b1);
                prev_addr  = bus.m_address;
                prev_data  = bus.m_writedata;
            end
        end
    end

    // Memory-side responder: 0 ready, 1 random stalls, 2 four-cycle stall per write, 3 stalled.
    initial begin
        stall_ctr = 0;
        bus.m_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wait_mode)
                1: bus.m_waitrequest = ($urandom_range(0, 2) == 0);
                2: begin
                    if (bus.m_write === 1'b1 && stall_ctr < 4) begin
                        bus.m_waitrequest = 1'b1;
                        stall_ctr++;
                    end else begin
                        bus.m_waitrequest = 1'b0;
                        stall_ctr = 0;
                    end
                end
                3: bus.m_waitrequest = 1'b1;
                default: bus.m_waitrequest = 1'b0;
            endcase
        end
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        irq_cnt  = 0;
        wcyc_cnt = 0;
        be_bad   = 0;
        stab_bad = 0;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.s_address   = a;
        bus.s_writedata = d;
        bus.s_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.s_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        bus.s_address = a;
        bus.s_read    = 1'b1;
        @(negedge clk);
        d = bus.s_readdata;
        bus.s_read = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input bit sof);
        @(posedge clk);
        #1;
        bus.st_valid = 1'b1;
        bus.st_data  = d;
        bus.st_sof   = sof;
    endtask

    task automatic stream_idle();
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
        bus.st_sof   = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] w, input logic [15:0] h, input logic [31:0] dst);
        csr_write(3'd0, sw16(w));
        csr_write(3'd1, sw16(h));
        csr_write(3'd2, bs32(dst));
        csr_write(3'd5, 32'h0);
    endtask

    task automatic wait_irq(input int budget, output bit ok);
        int k;
        k = 0;
        while (irq_cnt == 0 && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        ok = (irq_cnt != 0);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        bus.s_address = '0; bus.s_read = 1'b0; bus.s_write = 1'b0; bus.s_writedata = '0;
        bus.st_data = '0; bus.st_valid = 1'b0; bus.st_sof = 1'b0;
        wait_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        @(negedge clk);
        n_cmp++;
        if (bus.m_write !== 1'b0) begin n_bad++; $display("FAIL reset_mwrite: got %b want 0", bus.m_write); end
        n_cmp++;
        if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
        n_cmp++;
        if (bus.st_ready !== 1'b1) begin n_bad++; $display("FAIL reset_st_ready: got %b want 1", bus.st_ready); end
        n_cmp++;
        if (bus.s_readdata !== 32'hdeadbeef) begin n_bad++; $display("FAIL reset_noread: got %h want deadbeef", bus.s_readdata); end
        csr_read(3'd0, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_width: got %h want 0", rd); end
        csr_read(3'd2, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_dst: got %h want 0", rd); end
        csr_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_size: got %h want 0", rd); end
        csr_read(3'd5, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", rd); end
        csr_read(3'd3, rd);
        n_cmp++;
        if (rd !== 32'hdeadbeef) begin n_bad++; $display("FAIL reset_unmapped: got %h want deadbeef", rd); end
        csr_read(3'd6, rd);
        n_cmp++;
`ifdef CAPTURE_DROP_COUNT_EN
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_dropcnt: got %h want 0", rd); end
`else
        if (rd !== 32'hdeadbeef) begin n_bad++; $display("FAIL reset_reg6: got %h want deadbeef", rd); end
`endif
    endtask

    task automatic test_basic_frame();
        logic [31:0] rd;
        bit ok;
        clear_mon();
        wait_mode = 0;
        start_frame(16'd8, 16'd2, 32'h1000);
        csr_read(3'd0, rd);
        n_cmp++;
        if (rd !== 32'h00000800) begin n_bad++; $display("FAIL basic_width_rb: got %h want 00000800", rd); end
        for (int i = 0; i < 3; i++) send_beat(16'hbad0 + 16'(i), 1'b0);
        for (int i = 0; i < 16; i++) send_beat(16'(i + 1), i == 0);
        stream_idle();
        wait_irq(300, ok);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_irq_timeout: got %b want 1", ok); end
        n_cmp++;
        if (irq_cnt !== 1) begin n_bad++; $display("FAIL basic_irq_count: got %0d want 1", irq_cnt); end
        n_cmp++;
        if (wr_addr_q.size() !== 16) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 16", wr_addr_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== 31'h800 + 31'(i) || wr_data_q[i] !== 16'(i + 1)) begin
                n_bad++;
                $display("FAIL basic_write[%0d]: got a=%h d=%h want a=%h d=%h", i,
                         (i < wr_addr_q.size()) ? wr_addr_q[i] : 31'h0, (i < wr_data_q.size()) ? wr_data_q[i] : 16'h0,
                         31'h800 + 31'(i), 16'(i + 1));
            end
        end
        n_cmp++;
        if (be_bad !== 0) begin n_bad++; $display("FAIL basic_byteenable: got %0d bad cycles want 0", be_bad); end
        csr_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'h20000000) begin n_bad++; $display("FAIL basic_size: got %h want 20000000", rd); end
        csr_read(3'd5, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL basic_status: got %h want 0", rd); end
    endtask

    task automatic test_stall_hold();
        logic [31:0] rd;
        bit ok;
        clear_mon();
        wait_mode = 2;
        start_frame(16'd8, 16'd2, 32'h2000);
        for (int i = 0; i < 16; i++) send_beat(16'h2000 + 16'(i), i == 0);
        stream_idle();
        wait_irq(500, ok);
        repeat (3) @(posedge clk);
        wait_mode = 0;
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_irq_timeout: got %b want 1", ok); end
        n_cmp++;
        if (stab_bad !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stab_bad); end
        n_cmp++;
        if (wcyc_cnt < 80) begin n_bad++; $display("FAIL stall_cycles: got %0d write cycles want >=80", wcyc_cnt); end
        n_cmp++;
        if (wr_addr_q.size() !== 16) begin n_bad++; $display("FAIL stall_nwrites: got %0d want 16", wr_addr_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== 31'h1000 + 31'(i) || wr_data_q[i] !== 16'h2000 + 16'(i)) begin
                n_bad++;
                $display("FAIL stall_write[%0d]: wrong or missing, want a=%h d=%h", i, 31'h1000 + 31'(i), 16'h2000 + 16'(i));
            end
        end
        csr_read(3'd5, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL stall_status: got %h want 0", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        bit ok;
        clear_mon();
        wait_mode = 3;
        start_frame(16'd32, 16'd1, 32'h400);
        for (int i = 0; i < 32; i++) send_beat(16'h3000 + 16'(i), i == 0);
        stream_idle();
        repeat (8) @(posedge clk);
        wait_mode = 0;
        wait_irq(300, ok);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_irq_timeout: got %b want 1", ok); end
        n_cmp++;
        if (irq_cnt !== 1) begin n_bad++; $display("FAIL ovf_irq_count: got %0d want 1", irq_cnt); end
        n_cmp++;
        if (wr_addr_q.size() !== 16) begin n_bad++; $display("FAIL ovf_nwrites: got %0d want 16", wr_addr_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== 31'h200 + 31'(i) || wr_data_q[i] !== 16'h3000 + 16'(i)) begin
                n_bad++;
                $display("FAIL ovf_write[%0d]: wrong or missing, want a=%h d=%h", i, 31'h200 + 31'(i), 16'h3000 + 16'(i));
            end
        end
        csr_read(3'd5, rd);
        n_cmp++;
        if (rd !== 32'h04000000) begin n_bad++; $display("FAIL ovf_status: got %h want 04000000", rd); end
        csr_read(3'd4, rd);
        n_cmp++;
        if (rd !== bs32(32'd64)) begin n_bad++; $display("FAIL ovf_size: got %h want %h", rd, bs32(32'd64)); end
        csr_read(3'd6, rd);
        n_cmp++;
`ifdef CAPTURE_DROP_COUNT_EN
        if (rd !== bs32(32'd16)) begin n_bad++; $display("FAIL ovf_dropcnt: got %h want %h", rd, bs32(32'd16)); end
`else
        if (rd !== 32'hdeadbeef) begin n_bad++; $display("FAIL ovf_reg6: got %h want deadbeef", rd); end
`endif
    endtask

    task automatic test_sof_error();
        logic [31:0] rd;
        bit ok;
        clear_mon();
        wait_mode = 0;
        start_frame(16'd8, 16'd1, 32'h600);
        for (int i = 0; i < 8; i++) send_beat(16'h4000 + 16'(i), (i == 0) || (i == 5));
        stream_idle();
        wait_irq(200, ok);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL sof_irq_timeout: got %b want 1", ok); end
        n_cmp++;
        if (wr_addr_q.size() !== 8) begin n_bad++; $display("FAIL sof_nwrites: got %0d want 8", wr_addr_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== 31'h300 + 31'(i) || wr_data_q[i] !== 16'h4000 + 16'(i)) begin
                n_bad++;
                $display("FAIL sof_write[%0d]: wrong or missing, want a=%h d=%h", i, 31'h300 + 31'(i), 16'h4000 + 16'(i));
            end
        end
        csr_read(3'd5, rd);
        n_cmp++;
        if (rd !== 32'h02000000) begin n_bad++; $display("FAIL sof_status: got %h want 02000000", rd); end
    endtask

    task automatic test_zero_and_double_start();
        logic [31:0] rd;
        bit ok;
        clear_mon();
        wait_mode = 0;
        start_frame(16'd0, 16'd5, 32'h100);
        wait_irq(10, ok);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL zero_irq_timeout: got %b want 1", ok); end
        n_cmp++;
        if (irq_cnt !== 1) begin n_bad++; $display("FAIL zero_irq_count: got %0d want 1", irq_cnt); end
        n_cmp++;
        if (wcyc_cnt !== 0) begin n_bad++; $display("FAIL zero_mwrite: got %0d write cycles want 0", wcyc_cnt); end
        csr_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL zero_size: got %h want 0", rd); end

        clear_mon();
        start_frame(16'd4, 16'd1, 32'h700);
        send_beat(16'h5000, 1'b1);
        send_beat(16'h5001, 1'b0);
        stream_idle();
        csr_write(3'd5, 32'h0);
        send_beat(16'h5002, 1'b0);
        send_beat(16'h5003, 1'b0);
        stream_idle();
        wait_irq(200, ok);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL dstart_irq_timeout: got %b want 1", ok); end
        n_cmp++;
        if (irq_cnt !== 1) begin n_bad++; $display("FAIL dstart_irq_count: got %0d want 1", irq_cnt); end
        n_cmp++;
        if (wr_addr_q.size() !== 4) begin n_bad++; $display("FAIL dstart_nwrites: got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== 31'h380 + 31'(i) || wr_data_q[i] !== 16'h5000 + 16'(i)) begin
                n_bad++;
                $display("FAIL dstart_write[%0d]: wrong or missing, want a=%h d=%h", i, 31'h380 + 31'(i), 16'h5000 + 16'(i));
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic        mw, iq;
        bit          ok;
        int          k;
        clear_mon();
        wait_mode = 2;
        mw = 1'bx;
        iq = 1'bx;
        k  = 0;
        start_frame(16'd16, 16'd1, 32'h800);
        fork
            begin
                for (int i = 0; i < 16; i++) send_beat(16'h6000 + 16'(i), i == 0);
                stream_idle();
            end
            begin
                while (wr_addr_q.size() < 3 && k < 300) begin
                    @(posedge clk);
                    #2;
                    k++;
                end
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                mw = bus.m_write;
                iq = bus.irq;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        wait_mode = 0;
        repeat (5) @(posedge clk);
        n_cmp++;
        if (mw !== 1'b0) begin n_bad++; $display("FAIL rstmid_mwrite: got %b want 0", mw); end
        n_cmp++;
        if (iq !== 1'b0) begin n_bad++; $display("FAIL rstmid_irq: got %b want 0", iq); end
        n_cmp++;
        if (wr_addr_q.size() !== 3) begin n_bad++; $display("FAIL rstmid_abandon: got %0d writes want 3", wr_addr_q.size()); end
        n_cmp++;
        if (irq_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_irq: got %0d pulses want 0", irq_cnt); end
        csr_read(3'd5, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL rstmid_status: got %h want 0", rd); end
        csr_read(3'd2, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL rstmid_dst_cleared: got %h want 0", rd); end

        clear_mon();
        start_frame(16'd16, 16'd1, 32'h800);
        for (int i = 0; i < 16; i++) send_beat(16'h6100 + 16'(i), i == 0);
        stream_idle();
        wait_irq(300, ok);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart_irq: got %b want 1", ok); end
        n_cmp++;
        if (wr_addr_q.size() !== 16) begin n_bad++; $display("FAIL rstmid_restart_n: got %0d want 16", wr_addr_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== 31'h400 + 31'(i) || wr_data_q[i] !== 16'h6100 + 16'(i)) begin
                n_bad++;
                $display("FAIL rstmid_write[%0d]: wrong or missing, want a=%h d=%h", i, 31'h400 + 31'(i), 16'h6100 + 16'(i));
            end
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] rd, dst;
        logic [15:0] exp_data[$];
        logic [30:0] base;
        bit          ok;
        int          w, h, n, guard;
        for (int it = 0; it < 4; it++) begin
            clear_mon();
            exp_data.delete();
            wait_mode = 1;
            w   = $urandom_range(1, 12);
            h   = $urandom_range(1, 4);
            n   = w * h;
            dst = $urandom;
            base = dst[31:1];
            start_frame(16'(w), 16'(h), dst);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) send_beat(16'($urandom), 1'b0);
            guard = 0;
            for (int i = 0; i < n; i++) begin
                while ((i - wr_addr_q.size()) >= DEPTH - 2 && guard < 1000) begin
                    stream_idle();
                    guard++;
                end
                if ($urandom_range(0, 3) == 0) stream_idle();
                exp_data.push_back(16'($urandom));
                send_beat(exp_data[i], i == 0);
            end
            stream_idle();
            wait_irq(2000, ok);
            repeat (3) @(posedge clk);
            wait_mode = 0;
            n_cmp++;
            if (ok !== 1'b1) begin n_bad++; $display("FAIL rand%0d_irq_timeout: got %b want 1", it, ok); end
            n_cmp++;
            if (irq_cnt !== 1) begin n_bad++; $display("FAIL rand%0d_irq_count: got %0d want 1", it, irq_cnt); end
            n_cmp++;
            if (wr_addr_q.size() !== n) begin n_bad++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wr_addr_q.size(), n); end
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (i >= wr_addr_q.size() || wr_addr_q[i] !== base + 31'(i) || wr_data_q[i] !== exp_data[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d_write[%0d]: wrong or missing, want a=%h d=%h", it, i, base + 31'(i), exp_data[i]);
                end
            end
            n_cmp++;
            if (stab_bad !== 0) begin n_bad++; $display("FAIL rand%0d_hold: got %0d unstable cycles want 0", it, stab_bad); end
            csr_read(3'd4, rd);
            n_cmp++;
            if (rd !== bs32(32'(2 * n))) begin n_bad++; $display("FAIL rand%0d_size: got %h want %h", it, rd, bs32(32'(2 * n))); end
            csr_read(3'd5, rd);
            n_cmp++;
            if (rd !== 32'h0) begin n_bad++; $display("FAIL rand%0d_status: got %h want 0", it, rd); end
        end
    endtask

    initial begin
        wait_mode = 0;
        test_reset();
        test_basic_frame();
        test_stall_hold();
        test_overflow();
        test_sof_error();
        test_zero_and_double_start();
        test_reset_midframe();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
